gf180mcu_fd_sc_mcu9t5v0__sync_dbnc: RTL and testbench

Clocked input-conditioning stage that drives the library's non-inverting buffer cell (`buf`). It synchronises an asynchronous input `I` into the `CLK` domain and debounces it. Output `Z` changes only after the synchronised input has held a new level for `DB_CYCLES` consecutive clocks. It also emits single-cycle edge pulses, so a downstream buffer/driver sees a clean, glitch-free, clock-aligned level.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__sync_dbnc.sv | 82 ++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__sync_dbnc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_dbnc.sv
// Synchroniser plus debouncer ahead of the buffer cell: Z follows the synchronised
// input only after it has held a new level for DB_CYCLES enabled clocks.
module gf180mcu_fd_sc_mcu9t5v0__sync_dbnc #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 4,
  parameter logic RESET_VAL   = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic I,
  output logic Z,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   z_q, z_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   s;

  // I only ever reaches the first flop of the chain; S is the last stage.
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], I};
    cnt_d  = cnt_q;
    z_d    = z_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (EN) begin
      if (s == z_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        z_d    = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    // Holds automatically while EN is low because cnt_d equals cnt_q then.
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= '0;
      z_q    <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      busy_q <= busy_d;
    end
  end

  assign Z    = z_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sync_dbnc.sv
// Directed bench: a vector table for the default debouncer and a toggle sequence
// for a DB_CYCLES=1 / SYNC_STAGES=3 instance.
module tb_gf180mcu_fd_sc_mcu9t5v0__sync_dbnc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic rst_a, en_a, i_a;
  logic z_a, rise_a, fall_a, busy_a;

  gf180mcu_fd_sc_mcu9t5v0__sync_dbnc dut_a (
    .CLK  (clk),
    .RST  (rst_a),
    .EN   (en_a),
    .I    (i_a),
    .Z    (z_a),
    .RISE (rise_a),
    .FALL (fall_a),
    .BUSY (busy_a)
  );

  // Single-cycle debounce, three-stage synchroniser.
  logic rst_b, en_b, i_b;
  logic z_b, rise_b, fall_b, busy_b;

  gf180mcu_fd_sc_mcu9t5v0__sync_dbnc #(
    .SYNC_STAGES (3),
    .DB_CYCLES   (1),
    .RESET_VAL   (1'b0)
  ) dut_b (
    .CLK  (clk),
    .RST  (rst_b),
    .EN   (en_b),
    .I    (i_b),
    .Z    (z_b),
    .RISE (rise_b),
    .FALL (fall_b),
    .BUSY (busy_b)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       i;
    logic [3:0] expv;  // {Z, RISE, FALL, BUSY} after the edge
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic rst, logic en, logic i, logic [3:0] expv);
    vec_t v;
    v.rst  = rst;
    v.en   = en;
    v.i    = i;
    v.expv = expv;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got Z/RISE/FALL/BUSY=%b, want %b", name, got, want);
  endtask

  initial begin
    logic hist[$];
    logic exp_z, prev_z, exp_r, exp_f, cur_i;

    rst_a = 1'b1; en_a = 1'b1; i_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1; i_b = 1'b0;

    // Reset with I=1, second reset edge with EN=0 (reset overrides EN).
    vecs.push_back(mk(1, 1, 1, 4'b0000));
    vecs.push_back(mk(1, 0, 1, 4'b0000));
    // Rise: first post-reset capture edge, Z on the 5th edge after it.
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b1100));
    vecs.push_back(mk(0, 1, 1, 4'b1000));
    // Fall: I=0 held.
    vecs.push_back(mk(0, 1, 0, 4'b1000));
    vecs.push_back(mk(0, 1, 0, 4'b1000));
    vecs.push_back(mk(0, 1, 0, 4'b1001));
    vecs.push_back(mk(0, 1, 0, 4'b1001));
    vecs.push_back(mk(0, 1, 0, 4'b1001));
    vecs.push_back(mk(0, 1, 0, 4'b0010));
    vecs.push_back(mk(0, 1, 0, 4'b0000));
    // Glitch: I=1 for 3 clocks then 0; BUSY 3 cycles, Z stays 0.
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 1, 0, 4'b0000));
    vecs.push_back(mk(0, 1, 0, 4'b0000));
    // Enable pause after 2 counted edges: Z rises 3 edges late.
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 0, 1, 4'b0001));
    vecs.push_back(mk(0, 0, 1, 4'b0001));
    vecs.push_back(mk(0, 0, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b1100));
    vecs.push_back(mk(0, 1, 1, 4'b1000));
    // Reset at cnt=2 while Z=1 qualifies a fall: Z back to 0, no pulse.
    vecs.push_back(mk(0, 1, 0, 4'b1000));
    vecs.push_back(mk(0, 1, 0, 4'b1000));
    vecs.push_back(mk(0, 1, 0, 4'b1001));
    vecs.push_back(mk(0, 1, 0, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b0000));
    // Re-qualify a rise from zero.
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b0001));
    vecs.push_back(mk(0, 1, 1, 4'b1100));
    vecs.push_back(mk(0, 1, 1, 4'b1000));

    for (int n = 0; n < vecs.size(); n++) begin
      rst_a = vecs[n].rst;
      en_a  = vecs[n].en;
      i_a   = vecs[n].i;
      tick();
      $display("vec[%0d] rst=%b en=%b i=%b -> Z/RISE/FALL/BUSY=%b", n,
               vecs[n].rst, vecs[n].en, vecs[n].i, {z_a, rise_a, fall_a, busy_a});
      check($sformatf("vec[%0d]", n), {z_a, rise_a, fall_a, busy_a}, vecs[n].expv);
    end

    // DB_CYCLES=1, SYNC_STAGES=3: Z equals I applied three edges earlier.
    rst_b = 1'b1; i_b = 1'b0;
    tick();
    tick();
    check("db1_reset", {z_b, rise_b, fall_b, busy_b}, 4'b0000);
    rst_b  = 1'b0;
    prev_z = 1'b0;
    for (int n = 0; n < 24; n++) begin
      cur_i = ((n / 4) % 2 == 0) ? 1'b1 : 1'b0;
      i_b   = cur_i;
      hist.push_back(cur_i);
      tick();
      exp_z = (n >= 3) ? hist[n-3] : 1'b0;
      exp_r = exp_z & ~prev_z;
      exp_f = ~exp_z & prev_z;
      $display("db1[%0d] i=%b -> Z/RISE/FALL/BUSY=%b", n, cur_i, {z_b, rise_b, fall_b, busy_b});
      check($sformatf("db1[%0d]", n), {z_b, rise_b, fall_b, busy_b}, {exp_z, exp_r, exp_f, 1'b0});
      prev_z = exp_z;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
